// File: rtl/sample_window_buffer.sv
// sample_window_buffer: circular delay line pairing each accepted sample with the one leaving a W-sample window.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   window_load       latch window_size this cycle (clamped to 1..SIZE_MAX_WINDOW)
//   window_size       requested window length
//   in_valid, in_data sample strobe and sample, accepted every asserted cycle
//   out_valid         one cycle after each accepted sample
//   out_new_data      registered copy of the accepted sample
//   out_old_data      sample leaving the window, 0 while filling
//   out_window_full   window holds W valid samples including this one
//   window_err        sticky out-of-range load flag, built only with WINDOW_RANGE_CHECK_EN
module sample_window_buffer #(
  parameter int SIZE_DATA       = 16,
  parameter int SIZE_MAX_WINDOW = 64,
  parameter int SIZE_WINDOW     = 8,
  localparam int AW = $clog2(SIZE_MAX_WINDOW),
  localparam int WW = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 window_load,
  input  logic [WW-1:0]        window_size,
  input  logic                 in_valid,
  input  logic [SIZE_DATA-1:0] in_data,
  output logic                 out_valid,
  output logic [SIZE_DATA-1:0] out_new_data,
  output logic [SIZE_DATA-1:0] out_old_data,
  output logic                 out_window_full,
  output logic                 window_err
);
  typedef enum logic {FILL, RUN} state_t;
  state_t               state_q;
  logic [SIZE_DATA-1:0] mem [SIZE_MAX_WINDOW];
  logic [AW-1:0]        wr_ptr_q, rd_addr;
  logic [WW-1:0]        w_q, w_d, w_clamp, fill_q, fill_d, fill_base;
  logic                 full_d, use_mem, bad_size;
  always_comb begin
    bad_size  = window_size == '0 || window_size > WW'(SIZE_MAX_WINDOW);
    w_clamp   = window_size == '0 ? WW'(1) : window_size > WW'(SIZE_MAX_WINDOW) ? WW'(SIZE_MAX_WINDOW) : window_size;
    // a load takes effect for the sample accepted in the same cycle
    w_d       = window_load ? w_clamp : w_q;
    fill_base = window_load ? '0 : fill_q;
    use_mem   = !window_load && state_q == RUN;
    // W = depth wraps to the write address; the array read sees pre-write content
    rd_addr   = wr_ptr_q - w_d[AW-1:0];
    fill_d    = in_valid && fill_base < w_d ? fill_base + WW'(1) : fill_base;
    full_d    = fill_d == w_d;
  end
  always_ff @(posedge clk)
    if (in_valid && !reset) mem[wr_ptr_q] <= in_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FILL;
      wr_ptr_q        <= '0;
      fill_q          <= '0;
      w_q             <= WW'(SIZE_WINDOW);
      out_valid       <= 1'b0;
      out_new_data    <= '0;
      out_old_data    <= '0;
      out_window_full <= 1'b0;
    end else begin
      w_q       <= w_d;
      fill_q    <= fill_d;
      out_valid <= in_valid;
      state_q   <= in_valid && full_d ? RUN : window_load ? FILL : state_q;
      if (in_valid) begin
        wr_ptr_q        <= wr_ptr_q + AW'(1);
        out_new_data    <= in_data;
        out_old_data    <= use_mem ? mem[rd_addr] : '0;
        out_window_full <= full_d;
      end
    end
  end
`ifdef WINDOW_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk)
    if (reset) err_q <= 1'b0;
    else if (window_load && bad_size) err_q <= 1'b1;
  assign window_err = err_q;
`else
  logic unused_bad;
  assign unused_bad = bad_size;
  assign window_err = 1'b0;
`endif
endmodule

// File: doc/sample_window_buffer.md
# sample_window_buffer

Circular delay line directly upstream of the moving-average accumulator. Each accepted sample is presented together with the sample leaving the window (the one accepted W samples earlier), so the accumulator can update its running sum as sum + new − old. Window length W is runtime-loadable up to SIZE_MAX_WINDOW. Until W samples have entered since reset or the last reload, the departing sample is reported as zero.

## Interface
- SIZE_DATA, 16, sample width (two's complement)
- SIZE_MAX_WINDOW, 64, buffer depth; power of two, ≥ 2
- SIZE_WINDOW, 8, window length after reset (1..SIZE_MAX_WINDOW)
- Derived: AW = $clog2(SIZE_MAX_WINDOW); WW = AW+1
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- window_load  in  1  latch window_size this cycle
- window_size  in  WW  requested window length
- in_valid  in  1  sample strobe; no back-pressure, accepted every asserted cycle
- in_data  in  SIZE_DATA  input sample
- out_valid  out  1  one cycle after each accepted sample
- out_new_data  out  SIZE_DATA  registered copy of the accepted sample
- out_old_data  out  SIZE_DATA  sample leaving the window, or 0 during fill
- out_window_full  out  1  window holds W valid samples, including this one
- window_err  out  1  sticky out-of-range load flag (see Configuration)

## Operation
- Storage: SIZE_MAX_WINDOW × SIZE_DATA memory, write pointer wr_ptr (AW bits, wraps modulo depth).
- Accepted sample: write in_data at wr_ptr, read at (wr_ptr − W) mod depth, then wr_ptr++.
- Read-before-write: when W = SIZE_MAX_WINDOW the read and write addresses coincide; the read returns the pre-write content.
- Fill counter fill_cnt (WW bits) saturates at W.
- FSM:
  - FILL: fill_cnt < W. out_old_data = 0. Go to RUN when an accepted sample makes fill_cnt = W.
  - RUN: out_old_data = memory read.
  - window_load (any state): W ← clamped window_size, fill_cnt ← 0, go to FILL. wr_ptr and memory are untouched.
- Clamp: 0 → 1, > SIZE_MAX_WINDOW → SIZE_MAX_WINDOW.
- Simultaneous window_load and in_valid: the load applies first, then the sample is the first of the new window (fill_cnt = 1, out_old_data = 0, out_window_full = 1 only if the new W = 1).
- in_valid low: no write, no pointer or counter change; out_valid = 0; data outputs hold their last values.
- Reset values: wr_ptr = 0, fill_cnt = 0, W = SIZE_WINDOW, state FILL, out_valid = 0, out_new_data = 0, out_old_data = 0, out_window_full = 0, window_err = 0. Memory is not cleared; the FILL masking makes this unnecessary.
- Reset mid-stream: any in-flight output is dropped (out_valid = 0 on the next cycle) and filling restarts.

## Timing
- Latency: in_valid at edge t produces out_valid, out_new_data, out_old_data and out_window_full at t+1, all registered.
- Throughput: one sample per clock, sustained.
- window_load at edge t affects the sample accepted at edge t and every later sample.
- out_window_full rises with the output of the W-th sample after a load or reset.

## Configuration
- WINDOW_RANGE_CHECK_EN defined: window_err is set when window_load occurs with window_size = 0 or window_size > SIZE_MAX_WINDOW. It stays set until reset. The clamp still applies.
- WINDOW_RANGE_CHECK_EN undefined: window_err is tied to 0 and no check logic is built. The clamp still applies.

## Test plan
- Reset, then W = 8 and samples 1..20 on consecutive cycles:
  - out_old_data = 0 for samples 1–8; out_window_full first high with sample 8.
  - Sample 9 → out_old_data = 1; sample 20 → out_old_data = 12.
- Load window_size = 64, stream 200 samples (value = index):
  - Sample 65 → out_old_data = 1 (read-before-write at the coincident address).
  - Sample 200 → out_old_data = 136.
- Gapped input, W = 4: samples 10, 20, 30, 40, 50 with in_valid toggling every other cycle:
  - out_old_data = 10 with sample 50; out_valid never high two cycles in a row.
- Reload W = 3 with in_valid high after 20 samples at W = 8:
  - The reload sample gives out_old_data = 0 and out_window_full = 0.
  - The 4th sample after the reload gives the reload-cycle sample as out_old_data.
- Load window_size = 0, then 100:
  - Effective W = 1: each output's old data equals the previous sample.
  - Then W = 64; window_err = 1 only with WINDOW_RANGE_CHECK_EN defined.
- Assert reset at sample 5 of a W = 8 stream:
  - The next cycle has out_valid = 0, all outputs 0, W = 8.
  - Samples after reset report old data 0 until the 8th sample.
